key_tx_seq: RTL and testbench

Serialises the 256-bit decrypted key from the `AES` block into a framed byte stream for a single `uart_tx` instance. It sits between the key source (`AES.dec_o`) and the UART transmitter, and is triggered by the `pin` block's write-enable. It replaces any per-byte transmitter replication with one sequencer that drives `i_Tx_DV`/`i_Tx_Byte` and paces itself on `o_Tx_Done`.

Each transfer is a 34-byte frame: a start-of-frame byte, 32 key bytes, and an XOR checksum byte.

---
 rtl/key_tx_seq.sv | 126 ++++++++++++
 tb/tb_key_tx_seq.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_tx_seq.sv
// Frames a latched key as SOF, key bytes LSB-first, XOR checksum,
// and hands one byte at a time to a single UART transmitter.
module key_tx_seq #(
    parameter int         NUM_BYTES = 32,
    parameter logic [7:0] SOF_BYTE  = 8'hA5,
    parameter int         GAP_CLKS  = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [NUM_BYTES*8-1:0] key_i,
    input  logic                   tx_done_i,
    output logic                   tx_dv_o,
    output logic [7:0]             tx_byte_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int IW = $clog2(NUM_BYTES + 2);
    localparam int SW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int GW = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES + 1);
    localparam logic [IW-1:0] CSUM_IDX = IW'(NUM_BYTES);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CLKS);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_e;

    state_e                      state_q, state_d;
    logic                        start_q;
    logic [IW-1:0]               idx_q, idx_d;
    logic [7:0]                  csum_q, csum_d;
    logic [7:0]                  byte_q, byte_d;
    logic [NUM_BYTES-1:0][7:0]   key_q, key_d;
    logic [GW-1:0]               gap_q, gap_d;
    logic [7:0]                  key_byte;

    // idx_q names the byte on the wire; key byte idx_q is loaded next
    assign key_byte = key_q[idx_q[SW-1:0]];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        byte_d  = byte_q;
        key_d   = key_q;
        gap_d   = gap_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i && !start_q) begin
                    key_d   = key_i;
                    idx_d   = '0;
                    csum_d  = '0;
                    byte_d  = SOF_BYTE;
                    state_d = S_SEND;
                end
            end
            S_SEND: state_d = S_WAIT;
            S_WAIT: begin
                if (tx_done_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (idx_q == CSUM_IDX) begin
                            byte_d = csum_q;
                        end else begin
                            byte_d = key_byte;
                            csum_d = csum_q ^ key_byte;
                        end
                        if (GAP_CLKS > 0) begin
                            gap_d   = GAP_LOAD;
                            state_d = S_GAP;
                        end else begin
                            state_d = S_SEND;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_q <= GAP_ONE) begin
                    gap_d   = '0;
                    state_d = S_SEND;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            idx_q   <= '0;
            csum_q  <= '0;
            byte_q  <= '0;
            key_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_i;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            byte_q  <= byte_d;
            key_q   <= key_d;
            gap_q   <= gap_d;
        end
    end

    assign tx_dv_o   = (state_q == S_SEND);
    assign busy_o    = (state_q == S_SEND) || (state_q == S_WAIT) ||
                       (state_q == S_GAP);
    assign done_o    = (state_q == S_DONE);
    assign tx_byte_o = byte_q;

endmodule

// File: tb/tb_key_tx_seq.sv
// Bench for key_tx_seq: back-to-back instance (a) and GAP_CLKS=4 instance (b),
// each paced by a UART stand-in, frames checked against a list-built model.
module tb_key_tx_seq;

    localparam int NB = 32;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstn;
    logic            stA, stB;
    logic [NB*8-1:0] kA, kB;
    logic            udA = 1'b0, udB = 1'b0;
    logic            syA = 1'b0, syB = 1'b0;
    logic            tdA, tdB;
    logic            dvA, dvB, busyA, busyB, dnA, dnB;
    logic [7:0]      byA, byB;

    assign tdA = udA | syA;
    assign tdB = udB | syB;

    key_tx_seq #(.NUM_BYTES(NB), .SOF_BYTE(8'hA5), .GAP_CLKS(0)) u_a (
        .clk_i(clk), .rst_i(rstn), .start_i(stA), .key_i(kA),
        .tx_done_i(tdA), .tx_dv_o(dvA), .tx_byte_o(byA),
        .busy_o(busyA), .done_o(dnA)
    );

    key_tx_seq #(.NUM_BYTES(NB), .SOF_BYTE(8'hA5), .GAP_CLKS(4)) u_b (
        .clk_i(clk), .rst_i(rstn), .start_i(stB), .key_i(kB),
        .tx_done_i(tdB), .tx_dv_o(dvB), .tx_byte_o(byB),
        .busy_o(busyB), .done_o(dnB)
    );

    int total = 0, bad = 0;
    int cyc = 0;
    bq_t gotA, gotB;
    int dvcA = 0, dcA = 0, dvcB = 0, dcB = 0;
    int stabA = 0, stabB = 0, gapB = 0, gchkB = 0;
    int ucA = 0, ucB = 0, ldB = 0, fdA = 0, dcycA = 0;
    bit inwA = 0, inwB = 0, lvB = 0;
    logic [7:0] wbA, wbB;

    // UART stand-ins plus observation, all at the falling edge
    always @(negedge clk) begin
        cyc++;
        if (!rstn) begin
            udA = 0; udB = 0; ucA = 0; ucB = 0;
            inwA = 0; inwB = 0; lvB = 0;
        end else begin
            if (udA) inwA = 0;
            udA = 0;
            if (ucA > 0) begin
                ucA--;
                if (ucA == 0) udA = 1;
            end
            if (dvA) begin
                if (gotA.size() == 0) fdA = cyc;
                gotA.push_back(byA);
                dvcA++;
                ucA = 5;
                inwA = 1;
                wbA = byA;
            end else if (inwA && byA !== wbA) begin
                stabA++;
            end
            if (dnA) begin
                dcA++;
                dcycA = cyc;
            end

            if (udB) begin
                inwB = 0;
                ldB = cyc - 1;
                lvB = 1;
            end
            udB = 0;
            if (ucB > 0) begin
                ucB--;
                if (ucB == 0) udB = 1;
            end
            if (dvB) begin
                if (lvB) begin
                    gchkB++;
                    if (cyc - ldB != 5) gapB++;
                    lvB = 0;
                end
                gotB.push_back(byB);
                dvcB++;
                ucB = $urandom_range(2, 7);
                inwB = 1;
                wbB = byB;
            end else if (inwB && byB !== wbB) begin
                stabB++;
            end
            if (dnB) begin
                dcB++;
                lvB = 0;
            end
        end
    end

    function automatic bq_t frame_of(input logic [NB*8-1:0] k);
        bq_t f;
        logic [7:0] x;
        x = 8'h00;
        f.push_back(8'hA5);
        for (int i = 0; i < NB; i++) begin
            f.push_back(k[i*8 +: 8]);
            x = x ^ k[i*8 +: 8];
        end
        f.push_back(x);
        return f;
    endfunction

    function automatic logic [NB*8-1:0] rand_key();
        logic [NB*8-1:0] k;
        for (int i = 0; i < NB / 4; i++) k[i*32 +: 32] = $urandom;
        return k;
    endfunction

    task automatic wait_done(input bit useB, input int prev,
                             input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if ((useB ? dcB : dcA) > prev) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_bytes(input bit useB, input int n,
                              input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if ((useB ? gotB.size() : gotA.size()) >= n) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; stA = 0; stB = 0; kA = '0; kB = '0;
        repeat (3) @(negedge clk);
        total++;
        if (dvA !== 1'b0 || dvB !== 1'b0) begin
            bad++;
            $display("FAIL reset_dv got a=%b b=%b want 0", dvA, dvB);
        end
        total++;
        if (byA !== 8'h00 || byB !== 8'h00) begin
            bad++;
            $display("FAIL reset_byte got a=%h b=%h want 00", byA, byB);
        end
        total++;
        if (busyA !== 1'b0 || busyB !== 1'b0 || dnA !== 1'b0 || dnB !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy_done got %b%b%b%b want 0000",
                     busyA, busyB, dnA, dnB);
        end
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (dvcA != 0 || dvcB != 0 || busyA !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle got dv=%0d/%0d busy=%b want 0/0 0",
                     dvcA, dvcB, busyA);
        end
    endtask

    task automatic test_basic();
        bq_t exp;
        int pdv, pdn, pst, mism;
        bit ok;
        for (int i = 0; i < NB; i++) kA[i*8 +: 8] = 8'(i + 1);
        exp = frame_of(kA);
        gotA.delete();
        pdv = dvcA; pdn = dcA; pst = stabA;
        @(negedge clk) stA = 1'b1;
        @(negedge clk);
        total++;
        if (dvA !== 1'b1 || busyA !== 1'b1 || byA !== 8'hA5) begin
            bad++;
            $display("FAIL basic_first got dv=%b busy=%b byte=%h want 1 1 a5",
                     dvA, busyA, byA);
        end
        stA = 1'b0;
        wait_done(0, pdn, 1000, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL basic_timeout got no done want done");
        end
        mism = 0;
        for (int i = 0; i < exp.size() && i < gotA.size(); i++)
            if (gotA[i] !== exp[i]) mism++;
        total++;
        if (mism != 0 || gotA.size() != 34) begin
            bad++;
            $display("FAIL basic_bytes got %0d bytes %0d wrong want 34 bytes 0 wrong",
                     gotA.size(), mism);
        end
        total++;
        if (gotA.size() != 34 || gotA[33] !== 8'h20) begin
            bad++;
            $display("FAIL basic_csum got size %0d want checksum 20", gotA.size());
        end
        total++;
        if (dvcA - pdv != 34 || dcA - pdn != 1) begin
            bad++;
            $display("FAIL basic_counts got dv=%0d done=%0d want 34 1",
                     dvcA - pdv, dcA - pdn);
        end
        total++;
        if (dcycA - fdA != 204) begin
            bad++;
            $display("FAIL basic_len got %0d cycles want 204", dcycA - fdA);
        end
        total++;
        if (stabA != pst || busyA !== 1'b0) begin
            bad++;
            $display("FAIL basic_stable got unstable=%0d busy=%b want 0 0",
                     stabA - pst, busyA);
        end
    endtask

    task automatic test_level_held();
        bq_t exp;
        int pdv, pdn, mism;
        bit ok;
        kA = '1;
        exp = frame_of(kA);
        gotA.delete();
        pdv = dvcA; pdn = dcA;
        @(negedge clk) stA = 1'b1;
        repeat (1000) @(negedge clk);
        mism = 0;
        for (int i = 0; i < exp.size() && i < gotA.size(); i++)
            if (gotA[i] !== exp[i]) mism++;
        total++;
        if (mism != 0 || gotA.size() != 34 || gotA[33] !== 8'h00) begin
            bad++;
            $display("FAIL level_bytes got %0d bytes %0d wrong want 34 0",
                     gotA.size(), mism);
        end
        total++;
        if (dvcA - pdv != 34 || dcA - pdn != 1) begin
            bad++;
            $display("FAIL level_once got dv=%0d done=%0d want 34 1",
                     dvcA - pdv, dcA - pdn);
        end
        stA = 1'b0;
        @(negedge clk);
        kA = rand_key();
        exp = frame_of(kA);
        gotA.delete();
        pdn = dcA;
        stA = 1'b1;
        wait_done(0, pdn, 1000, ok);
        @(negedge clk) stA = 1'b0;
        mism = 0;
        for (int i = 0; i < exp.size() && i < gotA.size(); i++)
            if (gotA[i] !== exp[i]) mism++;
        total++;
        if (!ok || mism != 0 || gotA.size() != 34) begin
            bad++;
            $display("FAIL level_retrigger got ok=%0d %0d bytes %0d wrong want 1 34 0",
                     ok, gotA.size(), mism);
        end
    endtask

    task automatic test_lockout();
        bq_t exp;
        int pdv, pdn, mism;
        bit ok, ok2;
        kA = rand_key();
        exp = frame_of(kA);
        gotA.delete();
        pdv = dvcA; pdn = dcA;
        @(negedge clk) stA = 1'b1;
        @(negedge clk);
        @(negedge clk) stA = 1'b0;
        wait_bytes(0, 11, 500, ok);
        @(negedge clk) begin
            stA = 1'b1;
            kA = '0;
        end
        @(negedge clk) stA = 1'b0;
        wait_done(0, pdn, 1000, ok2);
        repeat (300) @(negedge clk);
        mism = 0;
        for (int i = 0; i < exp.size() && i < gotA.size(); i++)
            if (gotA[i] !== exp[i]) mism++;
        total++;
        if (!ok || !ok2 || mism != 0 || gotA.size() != 34) begin
            bad++;
            $display("FAIL lockout_bytes got ok=%0d%0d %0d bytes %0d wrong want 11 34 0",
                     ok, ok2, gotA.size(), mism);
        end
        total++;
        if (dvcA - pdv != 34 || dcA - pdn != 1) begin
            bad++;
            $display("FAIL lockout_extra got dv=%0d done=%0d want 34 1",
                     dvcA - pdv, dcA - pdn);
        end
    endtask

    task automatic test_reset_mid();
        bq_t exp;
        int pdv, pdn, mism;
        bit ok;
        kA = rand_key();
        gotA.delete();
        pdn = dcA;
        @(negedge clk) stA = 1'b1;
        @(negedge clk);
        @(negedge clk) stA = 1'b0;
        wait_bytes(0, 6, 500, ok);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (!ok || busyA !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_pre got ok=%0d busy=%b want 1 1", ok, busyA);
        end
        #2 rstn = 1'b0;
        #1;
        total++;
        if (dvA !== 1'b0 || busyA !== 1'b0 || dnA !== 1'b0 || byA !== 8'h00) begin
            bad++;
            $display("FAIL rstmid_now got dv=%b busy=%b done=%b byte=%h want 0 0 0 00",
                     dvA, busyA, dnA, byA);
        end
        pdv = dvcA;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (100) @(negedge clk);
        total++;
        if (dvcA != pdv || dcA != pdn) begin
            bad++;
            $display("FAIL rstmid_quiet got dv=%0d done=%0d want 0 0",
                     dvcA - pdv, dcA - pdn);
        end
        kA = rand_key();
        exp = frame_of(kA);
        gotA.delete();
        stA = 1'b1;
        wait_done(0, pdn, 1000, ok);
        @(negedge clk) stA = 1'b0;
        mism = 0;
        for (int i = 0; i < exp.size() && i < gotA.size(); i++)
            if (gotA[i] !== exp[i]) mism++;
        total++;
        if (!ok || mism != 0 || gotA.size() != 34) begin
            bad++;
            $display("FAIL rstmid_next got ok=%0d %0d bytes %0d wrong want 1 34 0",
                     ok, gotA.size(), mism);
        end
    endtask

    task automatic test_gap();
        bq_t exp;
        int pdn, pg, pgc, pst, mism;
        bit ok;
        kB = rand_key();
        exp = frame_of(kB);
        gotB.delete();
        pdn = dcB; pg = gapB; pgc = gchkB; pst = stabB;
        @(negedge clk) stB = 1'b1;
        @(negedge clk);
        @(negedge clk) stB = 1'b0;
        wait_done(1, pdn, 2000, ok);
        mism = 0;
        for (int i = 0; i < exp.size() && i < gotB.size(); i++)
            if (gotB[i] !== exp[i]) mism++;
        total++;
        if (!ok || mism != 0 || gotB.size() != 34) begin
            bad++;
            $display("FAIL gap_bytes got ok=%0d %0d bytes %0d wrong want 1 34 0",
                     ok, gotB.size(), mism);
        end
        total++;
        if (gchkB - pgc != 33 || gapB != pg) begin
            bad++;
            $display("FAIL gap_spacing got %0d gaps %0d wrong want 33 0",
                     gchkB - pgc, gapB - pg);
        end
        total++;
        if (stabB != pst) begin
            bad++;
            $display("FAIL gap_stable got %0d unstable cycles want 0", stabB - pst);
        end
    endtask

    task automatic test_stray();
        bq_t exp;
        int pdv, pdn, pg, mism;
        bit ok, ok2, ok3;
        pdv = dvcA;
        @(negedge clk) syA = 1'b1;
        @(negedge clk) syA = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (busyA !== 1'b0 || dvcA != pdv) begin
            bad++;
            $display("FAIL stray_idle got busy=%b dv=%0d want 0 0", busyA, dvcA - pdv);
        end
        kB = rand_key();
        exp = frame_of(kB);
        gotB.delete();
        pdn = dcB; pg = gapB;
        @(negedge clk) stB = 1'b1;
        @(negedge clk);
        @(negedge clk) stB = 1'b0;
        wait_bytes(1, 4, 500, ok);
        ok2 = 0;
        for (int i = 0; i < 50 && !ok2; i++) begin
            @(posedge clk);
            #1;
            if (udB) ok2 = 1;
        end
        @(negedge clk) syB = 1'b1;
        @(negedge clk) syB = 1'b0;
        wait_done(1, pdn, 2000, ok3);
        mism = 0;
        for (int i = 0; i < exp.size() && i < gotB.size(); i++)
            if (gotB[i] !== exp[i]) mism++;
        total++;
        if (!ok || !ok2 || !ok3 || mism != 0 || gotB.size() != 34 || gapB != pg) begin
            bad++;
            $display("FAIL stray_gap got ok=%0d%0d%0d %0d bytes %0d wrong gaps %0d want 111 34 0 0",
                     ok, ok2, ok3, gotB.size(), mism, gapB - pg);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_level_held();
        test_lockout();
        test_reset_mid();
        test_gap();
        test_stray();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
